// File: rtl/deparser_pkt_assembler.sv
`default_nettype none
// ============================================================================
// Module   : deparser_pkt_assembler
// Purpose  : Buffers tagged deparser header slices and re-joins each header
//            with its valid/ready payload into one backpressured packet stream.
// Revision : 1.0 - initial release
// ============================================================================
module deparser_pkt_assembler #(
    parameter int HEAD_WIDTH      = 512,
    parameter int TAG_WIDTH       = 10,
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_HEAD_SLICES = 4,
    parameter int BYTES_W         = 7
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
    input  logic                            i_pay_valid,
    output logic                            o_pay_ready,
    input  logic [HEAD_WIDTH-1:0]           i_pay_data,
    input  logic [BYTES_W-1:0]              i_pay_bytes,
    input  logic                            i_pay_last,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [HEAD_WIDTH-1:0]           o_data,
    output logic [BYTES_W-1:0]              o_bytes,
    output logic                            o_last,
    output logic [31:0]                     o_pkt_cnt,
    output logic [31:0]                     o_drop_cnt,
    output logic                            o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(MAX_HEAD_SLICES + 1);
    localparam int ENT_W = HEAD_WIDTH + BYTES_W + 2;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_head = 2'd1;
    localparam logic [1:0] c_st_pay  = 2'd2;
    localparam logic [1:0] c_st_disc = 2'd3;

    // Tag decode
    logic                 w_slice_vld;
    logic                 w_slice_tail;
    logic                 w_slice_start;
    logic                 w_unused_shift;
    logic [5:0]           w_offset;
    logic [BYTES_W-1:0]   w_slice_bytes;

    assign w_slice_vld    = i_head[HEAD_WIDTH];
    assign w_unused_shift = i_head[HEAD_WIDTH+1];
    assign w_slice_tail   = i_head[HEAD_WIDTH+2];
    assign w_slice_start  = i_head[HEAD_WIDTH+3];
    assign w_offset       = i_head[HEAD_WIDTH+4 +: 6];
    assign w_slice_bytes  = BYTES_W'(w_offset) + BYTES_W'(1);

    // Entry layout: {data, bytes, tail, discard}
    logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
    logic [CNT_W-1:0]     r_wptr;
    logic [CNT_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     w_count;
    logic [CNT_W-1:0]     w_free;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_admit;
    logic                 w_cont_ok;
    logic                 w_push;
    logic                 w_pop;
    logic [ENT_W-1:0]     w_wr_entry;

    logic                 r_in_hdr;
    logic                 r_drop_hdr;
    logic [SC_W-1:0]      r_slice_cnt;
    logic [31:0]          r_drop_cnt;
    logic                 r_overflow;

    assign w_count   = r_wptr - r_rptr;
    assign w_free    = CNT_W'(FIFO_DEPTH) - w_count;
    assign w_empty   = (w_count == '0);
    assign w_full    = (w_count == CNT_W'(FIFO_DEPTH));
    assign w_admit   = (w_free >= CNT_W'(MAX_HEAD_SLICES));
    assign w_cont_ok = r_in_hdr && !r_drop_hdr &&
                       (r_slice_cnt < SC_W'(MAX_HEAD_SLICES)) && !w_full;

    always_comb begin
        w_push     = 1'b0;
        w_wr_entry = {i_head[HEAD_WIDTH-1:0], w_slice_bytes, w_slice_tail, 1'b0};
        if (w_slice_vld) begin
            if (w_slice_start) begin
                if (w_admit) begin
                    w_push = 1'b1;
                end else if (!w_full) begin
                    // Discard token keeps the dropped header's payload paired
                    w_push     = 1'b1;
                    w_wr_entry = {{HEAD_WIDTH{1'b0}}, {BYTES_W{1'b0}}, 1'b1, 1'b1};
                end
            end else if (w_cont_ok) begin
                w_push = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[PTR_W-1:0]] <= w_wr_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + CNT_W'(1);
            if (w_pop)  r_rptr <= r_rptr + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in_hdr    <= 1'b0;
            r_drop_hdr  <= 1'b0;
            r_slice_cnt <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
        end else if (w_slice_vld) begin
            if (w_slice_start) begin
                r_slice_cnt <= SC_W'(1);
                r_in_hdr    <= w_admit;
                r_drop_hdr  <= !w_admit;
                if (!w_admit) begin
                    if (w_full) r_overflow <= 1'b1;
                    else        r_drop_cnt <= r_drop_cnt + 32'd1;
                end
            end else if (r_in_hdr && !r_drop_hdr) begin
                if (w_cont_ok) r_slice_cnt <= r_slice_cnt + SC_W'(1);
                else           r_overflow  <= 1'b1;
            end
            if (w_slice_tail) begin
                r_in_hdr   <= 1'b0;
                r_drop_hdr <= 1'b0;
            end
        end
    end

    // Read side
    logic [ENT_W-1:0]      w_head;
    logic [HEAD_WIDTH-1:0] w_head_data;
    logic [BYTES_W-1:0]    w_head_bytes;
    logic                  w_head_tail;
    logic                  w_head_disc;
    logic                  w_last_slice;
    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [SC_W-1:0]       r_rd_cnt;
    logic [31:0]           r_pkt_cnt;

    assign w_head       = r_mem[r_rptr[PTR_W-1:0]];
    assign w_head_data  = w_head[ENT_W-1 -: HEAD_WIDTH];
    assign w_head_bytes = w_head[2 +: BYTES_W];
    assign w_head_tail  = w_head[1];
    assign w_head_disc  = w_head[0];
    // A truncated header never delivers its tail, so the slice budget also ends it
    assign w_last_slice = w_head_tail || (r_rd_cnt == SC_W'(MAX_HEAD_SLICES - 1));
    assign w_pop = ((r_state == c_st_idle) && !w_empty && w_head_disc) ||
                   ((r_state == c_st_head) && !w_empty && i_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= c_st_idle;
            r_rd_cnt  <= '0;
            r_pkt_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_st_head && w_pop) begin
                r_rd_cnt <= w_last_slice ? '0 : r_rd_cnt + SC_W'(1);
            end else if (r_state == c_st_idle) begin
                r_rd_cnt <= '0;
            end
            if (r_state == c_st_pay && i_pay_valid && i_ready && i_pay_last) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (!w_empty) w_next = w_head_disc ? c_st_disc : c_st_head;
            c_st_head: if (w_pop && w_last_slice) w_next = c_st_pay;
            c_st_pay:  if (i_pay_valid && i_ready && i_pay_last) w_next = c_st_idle;
            c_st_disc: if (i_pay_valid && i_pay_last) w_next = c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    always_comb begin
        o_valid     = 1'b0;
        o_pay_ready = 1'b0;
        o_data      = '0;
        o_bytes     = '0;
        o_last      = 1'b0;
        case (r_state)
            c_st_head: begin
                o_valid = !w_empty;
                o_data  = w_head_data;
                o_bytes = w_head_bytes;
            end
            c_st_pay: begin
                o_valid     = i_pay_valid;
                o_pay_ready = i_ready;
                o_data      = i_pay_data;
                o_bytes     = i_pay_bytes;
                o_last      = i_pay_last;
            end
            c_st_disc: o_pay_ready = 1'b1;
            default: ;
        endcase
    end

    assign o_pkt_cnt  = r_pkt_cnt;
    assign o_drop_cnt = r_drop_cnt;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_deparser_pkt_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_deparser_pkt_assembler
// Purpose  : Scoreboard bench for deparser_pkt_assembler with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deparser_pkt_assembler;

    localparam int HW = 512;
    localparam int TW = 10;
    localparam int BW = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic [HW+TW-1:0] head;
    logic            pay_valid;
    logic            pay_ready;
    logic [HW-1:0]   pay_data;
    logic [BW-1:0]   pay_bytes;
    logic            pay_last;
    logic            valid;
    logic            ready;
    logic [HW-1:0]   data;
    logic [BW-1:0]   bytes;
    logic            last;
    logic [31:0]     pkt_cnt;
    logic [31:0]     drop_cnt;
    logic            overflow;

    deparser_pkt_assembler dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_head      (head),
        .i_pay_valid (pay_valid),
        .o_pay_ready (pay_ready),
        .i_pay_data  (pay_data),
        .i_pay_bytes (pay_bytes),
        .i_pay_last  (pay_last),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_data      (data),
        .o_bytes     (bytes),
        .o_last      (last),
        .o_pkt_cnt   (pkt_cnt),
        .o_drop_cnt  (drop_cnt),
        .o_overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [HW-1:0] data;
        logic [BW-1:0] bytes;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t pay_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act[63:0], req[63:0]);
        end
    endtask

    function automatic logic [HW-1:0] pat(input int k);
        return {16{32'hC0DE_0000 + 32'(k)}};
    endfunction

    function automatic logic [HW+TW-1:0] mk(input logic [HW-1:0] d, input logic st,
                                            input logic tl, input logic [5:0] off);
        return {off, st, tl, 1'b0, 1'b1, d};
    endfunction

    task automatic exp_push(input logic [HW-1:0] d, input int b, input logic l);
        exp_q.push_back('{data: d, bytes: BW'(b), last: l});
    endtask

    task automatic pay_push(input logic [HW-1:0] d, input int b, input logic l);
        pay_q.push_back('{data: d, bytes: BW'(b), last: l});
    endtask

    task automatic send(input logic [HW-1:0] d, input logic st, input logic tl, input logic [5:0] off);
        head = mk(d, st, tl, off);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string nm);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || pay_q.size() != 0) && i < 300) begin
            @(posedge clk);
            i++;
        end
        #1;
        n_tests++;
        if (i >= 300) begin
            n_fail++;
            $display("FAIL %s: drain timed out, got %0d outputs pending, required 0", nm, exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: every accepted output beat must match the next expected beat
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %0h bytes %0d, required no output", data[63:0], bytes);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("out_data", data, e.data);
                check("out_bytes", HW'(bytes), HW'(e.bytes));
                check("out_last", HW'(last), HW'(e.last));
            end
        end
    end

    // Payload source: presents queued beats, advances on handshake
    initial begin
        bit fire;
        pay_valid = 1'b0;
        pay_data  = '0;
        pay_bytes = '0;
        pay_last  = 1'b0;
        forever begin
            @(negedge clk);
            fire = pay_valid && pay_ready;
            @(posedge clk); #1;
            if (fire && pay_q.size() > 0) void'(pay_q.pop_front());
            if (pay_q.size() > 0) begin
                pay_valid = 1'b1;
                {pay_data, pay_bytes, pay_last} = pay_q[0];
            end else begin
                pay_valid = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst   = 1'b1;
        ready = 1'b0;
        head  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_valid", HW'(valid), HW'(0));
        check("rst_pay_ready", HW'(pay_ready), HW'(0));
        check("rst_last", HW'(last), HW'(0));
        check("rst_data", data, HW'(0));
        check("rst_bytes", HW'(bytes), HW'(0));
        check("rst_pkt_cnt", HW'(pkt_cnt), HW'(0));
        check("rst_drop_cnt", HW'(drop_cnt), HW'(0));
        check("rst_overflow", HW'(overflow), HW'(0));

        // Single header, then payload
        @(posedge clk); #1;
        ready = 1'b1;
        exp_push(pat(1), 14, 1'b0);
        exp_push(pat(2), 64, 1'b0);
        exp_push(pat(3), 20, 1'b1);
        pay_push(pat(2), 64, 1'b0);
        pay_push(pat(3), 20, 1'b1);
        send(pat(1), 1'b1, 1'b1, 6'd13);
        head = '0;
        @(negedge clk);
        check("lat_early", HW'(valid), HW'(0));
        @(negedge clk);
        check("lat_first", HW'(valid), HW'(1));
        wait_drain("t1_drain");
        check("t1_pkt_cnt", HW'(pkt_cnt), HW'(1));

        // Multi-slice header under backpressure
        ready = 1'b0;
        exp_push(pat(10), 64, 1'b0);
        exp_push(pat(11), 64, 1'b0);
        exp_push(pat(12), 6, 1'b0);
        exp_push(pat(13), 10, 1'b1);
        pay_push(pat(13), 10, 1'b1);
        send(pat(10), 1'b1, 1'b0, 6'd63);
        send(pat(11), 1'b0, 1'b0, 6'd63);
        send(pat(12), 1'b0, 1'b1, 6'd5);
        head = '0;
        k = 0;
        @(negedge clk);
        while (!valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("bp_first_valid", HW'(valid), HW'(1));
        check("bp_hold0a", data, pat(10));
        @(negedge clk);
        check("bp_hold0b", data, pat(10));
        check("bp_hold0_bytes", HW'(bytes), HW'(64));
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        check("bp_hold1a", data, pat(11));
        @(negedge clk);
        check("bp_hold1b", data, pat(11));
        @(posedge clk); #1 ready = 1'b1;
        wait_drain("t2_drain");
        check("t2_pkt_cnt", HW'(pkt_cnt), HW'(2));

        // Admission drop: 13 entries queued leaves 3 free
        ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            for (int s = 0; s < 4; s++) begin
                exp_push(pat(20 + 4 * h + s), (s == 3) ? 8 : 64, 1'b0);
                send(pat(20 + 4 * h + s), s == 0, s == 3, (s == 3) ? 6'd7 : 6'd63);
            end
            exp_push(pat(40 + h), 32, 1'b1);
            pay_push(pat(40 + h), 32, 1'b1);
        end
        exp_push(pat(35), 1, 1'b0);
        exp_push(pat(43), 2, 1'b1);
        pay_push(pat(43), 2, 1'b1);
        send(pat(35), 1'b1, 1'b1, 6'd0);
        send(pat(50), 1'b1, 1'b0, 6'd63);
        send(pat(51), 1'b0, 1'b1, 6'd63);
        head = '0;
        pay_push(pat(60), 64, 1'b0);
        pay_push(pat(61), 64, 1'b0);
        pay_push(pat(62), 3, 1'b1);
        @(negedge clk);
        check("drop_cnt", HW'(drop_cnt), HW'(1));
        check("drop_no_overflow", HW'(overflow), HW'(0));
        @(posedge clk); #1 ready = 1'b1;
        wait_drain("t3_drain");
        check("t3_pay_consumed", HW'(pay_q.size()), HW'(0));
        check("t3_pkt_cnt", HW'(pkt_cnt), HW'(6));
        check("t3_drop_cnt", HW'(drop_cnt), HW'(1));

        // Truncation: fifth slice is not emitted, payload still follows
        for (int s = 0; s < 4; s++) exp_push(pat(70 + s), 64, 1'b0);
        exp_push(pat(75), 40, 1'b1);
        pay_push(pat(75), 40, 1'b1);
        for (int s = 0; s < 5; s++) send(pat(70 + s), s == 0, s == 4, (s == 4) ? 6'd9 : 6'd63);
        head = '0;
        @(negedge clk);
        check("trunc_overflow", HW'(overflow), HW'(1));
        wait_drain("t4_drain");
        check("t4_pkt_cnt", HW'(pkt_cnt), HW'(7));

        // Reset while in PAY
        exp_push(pat(80), 4, 1'b0);
        send(pat(80), 1'b1, 1'b1, 6'd3);
        head = '0;
        wait_drain("t5_head");
        check("t5_in_pay", HW'(pay_ready), HW'(1));
        do_reset();
        @(negedge clk);
        check("t5_valid", HW'(valid), HW'(0));
        check("t5_pay_ready", HW'(pay_ready), HW'(0));
        check("t5_pkt_cnt", HW'(pkt_cnt), HW'(0));
        check("t5_drop_cnt", HW'(drop_cnt), HW'(0));
        check("t5_overflow", HW'(overflow), HW'(0));
        repeat (3) @(negedge clk);
        check("t5_fifo_empty", HW'(valid), HW'(0));
        @(posedge clk); #1;
        exp_push(pat(81), 5, 1'b0);
        exp_push(pat(82), 12, 1'b1);
        pay_push(pat(82), 12, 1'b1);
        send(pat(81), 1'b1, 1'b1, 6'd4);
        head = '0;
        wait_drain("t5_drain");
        check("t5_new_pkt_cnt", HW'(pkt_cnt), HW'(1));

        // Back-to-back one-slice packets
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_push(pat(90 + i), i + 1, 1'b0);
            exp_push(pat(100 + i), 8 * i + 1, 1'b1);
            pay_push(pat(100 + i), 8 * i + 1, 1'b1);
        end
        for (int i = 0; i < 8; i++) send(pat(90 + i), 1'b1, 1'b1, 6'(i));
        head = '0;
        wait_drain("t6_drain");
        check("t6_pkt_cnt", HW'(pkt_cnt), HW'(8));
        check("t6_drop_cnt", HW'(drop_cnt), HW'(0));
        check("t6_overflow", HW'(overflow), HW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
